// File: rtl/float_to_fixed_conv_pkg.sv
// Shared constants for the float-to-fixed converter: rounding mode
// encodings, status flag bit positions and float field position helpers.
package float_conv_pkg;

    // Rounding modes carried alongside each input word
    localparam logic [1:0] ROUND_TRUNC     = 2'b00;  // toward zero
    localparam logic [1:0] ROUND_NEAR_AWAY = 2'b01;  // nearest, ties away from zero
    localparam logic [1:0] ROUND_NEAR_EVEN = 2'b10;  // nearest, ties to even
    localparam logic [1:0] ROUND_FLOOR     = 2'b11;  // toward -inf

    // Bit positions inside out_flags = {invalid, overflow, inexact}
    localparam int unsigned FLAG_INEXACT  = 0;
    localparam int unsigned FLAG_OVERFLOW = 1;
    localparam int unsigned FLAG_INVALID  = 2;
    localparam int unsigned FLAG_WIDTH    = 3;

    // Total float word width: sign + exponent + stored mantissa
    function automatic int unsigned float_width(input int unsigned mant_bits,
                                                input int unsigned exp_bits);
        return 1 + mant_bits + exp_bits;
    endfunction

    // Bit index of the sign bit
    function automatic int unsigned float_sign_pos(input int unsigned mant_bits,
                                                   input int unsigned exp_bits);
        return mant_bits + exp_bits;
    endfunction

    // Bit index of the exponent field LSB
    function automatic int unsigned float_exp_lsb(input int unsigned mant_bits);
        return mant_bits;
    endfunction

    // Exponent bias 2^(exp_bits-1)-1
    function automatic int unsigned float_bias(input int unsigned exp_bits);
        return (32'd1 << (exp_bits - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/float_to_fixed_conv_unpack.sv
// Combinational float unpack/classify for the first converter stage.
// Splits the word into fields, classifies zero/denormal, inf and NaN, and
// produces the effective exponent exp - bias + FRACTION_BITS as a signed
// value two bits wider than the exponent field.
module float_unpack
    import float_conv_pkg::*;
#(
    parameter int unsigned MANTISSA_SIZE = 23,
    parameter int unsigned EXPONENT_SIZE = 8,
    parameter int unsigned FRACTION_BITS = 0
) (
    input  logic [float_width(MANTISSA_SIZE, EXPONENT_SIZE)-1:0] i_data,
    output logic                                                 o_sign,
    output logic [MANTISSA_SIZE-1:0]                             o_mant,
    output logic                                                 o_zero_den,
    output logic                                                 o_inf,
    output logic                                                 o_nan,
    output logic signed [EXPONENT_SIZE+1:0]                      o_eff_exp
);

    localparam int unsigned SIGN_POS   = float_sign_pos(MANTISSA_SIZE, EXPONENT_SIZE);
    localparam int unsigned EXP_LSB    = float_exp_lsb(MANTISSA_SIZE);
    localparam int          EFF_OFFSET = int'(FRACTION_BITS) - int'(float_bias(EXPONENT_SIZE));

    logic [EXPONENT_SIZE-1:0] w_exp;
    logic                     w_exp_max;
    logic                     w_mant_nz;

    assign w_exp      = i_data[SIGN_POS-1:EXP_LSB];
    assign o_sign     = i_data[SIGN_POS];
    assign o_mant     = i_data[MANTISSA_SIZE-1:0];
    assign w_exp_max  = &w_exp;
    assign w_mant_nz  = |o_mant;
    assign o_zero_den = (w_exp == '0);
    assign o_inf      = w_exp_max & ~w_mant_nz;
    assign o_nan      = w_exp_max & w_mant_nz;
    assign o_eff_exp  = $signed({2'b00, w_exp}) + $signed(EFF_OFFSET[EXPONENT_SIZE+1:0]);

endmodule

// File: rtl/float_to_fixed_conv.sv
// Pipelined float -> signed fixed-point converter with valid/ready handshake.
// S1 unpack/classify, S2 align shift with guard/sticky, S3 round, negate and
// saturate into the output registers. All stages advance together on
// en = !out_valid | out_ready; bubbles are carried, not collapsed.
// Optional status flags are built when FLOAT_TO_FIXED_FLAGS_EN is defined;
// otherwise out_flags is tied to zero and the data path is unchanged.
module float_to_fixed_conv
    import float_conv_pkg::*;
#(
    parameter int unsigned MANTISSA_SIZE = 23,
    parameter int unsigned EXPONENT_SIZE = 8,
    parameter int unsigned INT_SIZE      = 32,
    parameter int unsigned FRACTION_BITS = 0
) (
    input  logic                                                 clk,
    input  logic                                                 resetn,
    input  logic                                                 in_valid,
    output logic                                                 in_ready,
    input  logic [float_width(MANTISSA_SIZE, EXPONENT_SIZE)-1:0] in_data,
    input  logic [1:0]                                           in_round,
    output logic                                                 out_valid,
    input  logic                                                 out_ready,
    output logic [INT_SIZE-1:0]                                  out_data,
    output logic [FLAG_WIDTH-1:0]                                out_flags
);

    localparam int unsigned M     = MANTISSA_SIZE;
    localparam int unsigned EW    = EXPONENT_SIZE + 2;
    localparam int unsigned WW    = M + 1 + INT_SIZE;
    localparam int          S_M   = int'(MANTISSA_SIZE);
    localparam int          S_INT = int'(INT_SIZE);
    localparam logic [INT_SIZE-1:0] MAX_POS = {1'b0, {(INT_SIZE-1){1'b1}}};
    localparam logic [INT_SIZE-1:0] MIN_NEG = {1'b1, {(INT_SIZE-1){1'b0}}};

    logic w_en;
    logic r_out_valid;
    logic [INT_SIZE-1:0] r_out_data;

    assign w_en      = ~r_out_valid | out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    // ---------------- S1: unpack / classify ----------------
    logic                 w_sign;
    logic [M-1:0]         w_mant;
    logic                 w_zero_den;
    logic                 w_inf;
    logic                 w_nan;
    logic signed [EW-1:0] w_eff_exp;

    float_unpack #(
        .MANTISSA_SIZE(MANTISSA_SIZE),
        .EXPONENT_SIZE(EXPONENT_SIZE),
        .FRACTION_BITS(FRACTION_BITS)
    ) u_unpack (
        .i_data    (in_data),
        .o_sign    (w_sign),
        .o_mant    (w_mant),
        .o_zero_den(w_zero_den),
        .o_inf     (w_inf),
        .o_nan     (w_nan),
        .o_eff_exp (w_eff_exp)
    );

    logic                 r1_valid;
    logic                 r1_sign;
    logic [M-1:0]         r1_mant;
    logic                 r1_zero_den;
    logic                 r1_inf;
    logic                 r1_nan;
    logic signed [EW-1:0] r1_eff_exp;
    logic [1:0]           r1_round;

    // S1 valid: cleared by reset, loads in_valid (bubble when low) on advance
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r1_valid <= 1'b0;
        end else if (w_en) begin
            r1_valid <= in_valid;
        end
    end

    // S1 data: unpacked fields, captured on advance
    always_ff @(posedge clk) begin
        if (w_en) begin
            r1_sign     <= w_sign;
            r1_mant     <= w_mant;
            r1_zero_den <= w_zero_den;
            r1_inf      <= w_inf;
            r1_nan      <= w_nan;
            r1_eff_exp  <= w_eff_exp;
            r1_round    <= in_round;
        end
    end

    // ---------------- S2: align shift with guard/sticky ----------------
    logic                w_huge;
    logic                w_guard;
    logic                w_sticky;
    logic [INT_SIZE-1:0] w_mag;
    logic signed [31:0]  w_e;
    logic [31:0]         w_amt;
    logic [M:0]          w_full;
    logic [WW-1:0]       w_wide;

    // Position the hidden-bit significand so bit e lands on the integer MSB;
    // right shifts go through a zero-padded window so dropped bits become guard/sticky
    always_comb begin
        w_full   = {1'b1, r1_mant};
        w_e      = {{(32-EW){r1_eff_exp[EW-1]}}, r1_eff_exp};
        w_amt    = '0;
        w_wide   = '0;
        w_mag    = '0;
        w_huge   = 1'b0;
        w_guard  = 1'b0;
        w_sticky = 1'b0;
        if (w_e >= S_INT) begin
            w_huge = 1'b1;
        end else if (w_e >= S_M) begin
            w_amt = w_e - S_M;
            w_mag = {{(INT_SIZE-M-1){1'b0}}, w_full} << w_amt;
        end else if (w_e > S_M - S_INT) begin
            w_amt    = S_M - w_e;
            w_wide   = {w_full, {INT_SIZE{1'b0}}} >> w_amt;
            w_mag    = {{(INT_SIZE-M-1){1'b0}}, w_wide[WW-1:INT_SIZE]};
            w_guard  = w_wide[INT_SIZE-1];
            w_sticky = |w_wide[INT_SIZE-2:0];
        end else begin
            w_sticky = 1'b1;
        end
    end

    logic                r2_valid;
    logic                r2_sign;
    logic [INT_SIZE-1:0] r2_mag;
    logic                r2_huge;
    logic                r2_guard;
    logic                r2_sticky;
    logic                r2_zero_den;
    logic                r2_inf;
    logic                r2_nan;
    logic [1:0]          r2_round;

    // S2 valid: follows S1 valid on advance
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r2_valid <= 1'b0;
        end else if (w_en) begin
            r2_valid <= r1_valid;
        end
    end

    // S2 data: aligned magnitude and rounding context
    always_ff @(posedge clk) begin
        if (w_en) begin
            r2_sign     <= r1_sign;
            r2_mag      <= w_mag;
            r2_huge     <= w_huge;
            r2_guard    <= w_guard;
            r2_sticky   <= w_sticky;
            r2_zero_den <= r1_zero_den;
            r2_inf      <= r1_inf;
            r2_nan      <= r1_nan;
            r2_round    <= r1_round;
        end
    end

    // ---------------- S3: round / negate / saturate ----------------
    logic                w_inc;
    logic [INT_SIZE:0]   w_sum;
    logic                w_ovf;
    logic [INT_SIZE-1:0] w_sat;
    logic [INT_SIZE-1:0] w_res;

    // Round the magnitude, then test range after the carry so -2^(N-1) survives
    always_comb begin
        case (r2_round)
            ROUND_TRUNC:     w_inc = 1'b0;
            ROUND_NEAR_AWAY: w_inc = r2_guard;
            ROUND_NEAR_EVEN: w_inc = r2_guard & (r2_sticky | r2_mag[0]);
            default:         w_inc = r2_sign & (r2_guard | r2_sticky);
        endcase
        w_sum = {1'b0, r2_mag} + {{INT_SIZE{1'b0}}, w_inc};
        if (r2_sign) begin
            w_ovf = r2_huge | w_sum[INT_SIZE] | (w_sum[INT_SIZE-1] & (|w_sum[INT_SIZE-2:0]));
        end else begin
            w_ovf = r2_huge | w_sum[INT_SIZE] | w_sum[INT_SIZE-1];
        end
        w_sat = r2_sign ? MIN_NEG : MAX_POS;
        if (r2_nan || r2_zero_den) begin
            w_res = '0;
        end else if (r2_inf || w_ovf) begin
            w_res = w_sat;
        end else if (r2_sign) begin
            w_res = -w_sum[INT_SIZE-1:0];
        end else begin
            w_res = w_sum[INT_SIZE-1:0];
        end
    end

    // Output register: cleared by reset, held while stalled
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_en) begin
            r_out_valid <= r2_valid;
            r_out_data  <= w_res;
        end
    end

`ifdef FLOAT_TO_FIXED_FLAGS_EN
    logic                  r2_mant_nz;
    logic [FLAG_WIDTH-1:0] w_flags;
    logic [FLAG_WIDTH-1:0] r_out_flags;

    // Denormal inexactness needs the mantissa test carried past S1
    always_ff @(posedge clk) begin
        if (w_en) begin
            r2_mant_nz <= |r1_mant;
        end
    end

    // Status flags mirror the priority of the result selection above
    always_comb begin
        w_flags = '0;
        if (r2_nan) begin
            w_flags[FLAG_INVALID] = 1'b1;
        end else if (r2_inf) begin
            w_flags[FLAG_OVERFLOW] = 1'b1;
        end else if (r2_zero_den) begin
            w_flags[FLAG_INEXACT] = r2_mant_nz;
        end else if (w_ovf) begin
            w_flags[FLAG_OVERFLOW] = 1'b1;
        end else begin
            w_flags[FLAG_INEXACT] = r2_guard | r2_sticky;
        end
    end

    // Flag output register, same enable/reset as the data register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_out_flags <= '0;
        end else if (w_en) begin
            r_out_flags <= w_flags;
        end
    end

    assign out_flags = r_out_flags;
`else
    assign out_flags = '0;
`endif

endmodule

// File: tb/tb_float_to_fixed_conv.sv
// Scoreboard bench for float_to_fixed_conv: directed vectors push expected
// results into a queue, a negedge monitor compares every presented output.
module tb_float_to_fixed_conv;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [1:0]  in_round;
    logic [2:0]  out_flags;

    logic        f4_valid, f4_in_ready, f4_out_valid, f4_ready;
    logic [31:0] f4_data, f4_out_data;
    logic [1:0]  f4_round;
    logic [2:0]  f4_out_flags;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  f;
    } exp_t;

    exp_t q[$];
    exp_t q4[$];
    int unsigned total = 0;
    int unsigned bad   = 0;
    bit          rdy_mode = 1'b0;

`ifdef FLOAT_TO_FIXED_FLAGS_EN
    localparam logic [2:0] FLAG_MASK = 3'b111;
`else
    localparam logic [2:0] FLAG_MASK = 3'b000;
`endif
    localparam logic [2:0] NF = 3'b000, NX = 3'b001, OV = 3'b010, NV = 3'b100;

    always #5 clk = ~clk;

    float_to_fixed_conv #(
        .MANTISSA_SIZE(23), .EXPONENT_SIZE(8), .INT_SIZE(32), .FRACTION_BITS(0)
    ) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_round(in_round), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags)
    );

    float_to_fixed_conv #(
        .MANTISSA_SIZE(23), .EXPONENT_SIZE(8), .INT_SIZE(32), .FRACTION_BITS(4)
    ) dut_f4 (
        .clk(clk), .resetn(resetn), .in_valid(f4_valid), .in_ready(f4_in_ready),
        .in_data(f4_data), .in_round(f4_round), .out_valid(f4_out_valid),
        .out_ready(f4_ready), .out_data(f4_out_data), .out_flags(f4_out_flags)
    );

    // Main monitor: compare head of queue on every presented output, pop on handshake
    always @(negedge clk) begin
        if (resetn && out_valid) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out: got data=%h flags=%b, required no output", out_data, out_flags);
            end else begin
                if (out_data !== q[0].d || out_flags !== q[0].f) begin
                    bad++;
                    $display("FAIL out: got data=%h flags=%b, required data=%h flags=%b",
                             out_data, out_flags, q[0].d, q[0].f);
                end
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    // FRACTION_BITS=4 monitor
    always @(negedge clk) begin
        if (resetn && f4_out_valid) begin
            total++;
            if (q4.size() == 0) begin
                bad++;
                $display("FAIL f4_unexpected_out: got data=%h, required no output", f4_out_data);
            end else begin
                if (f4_out_data !== q4[0].d || f4_out_flags !== q4[0].f) begin
                    bad++;
                    $display("FAIL f4_out: got data=%h flags=%b, required data=%h flags=%b",
                             f4_out_data, f4_out_flags, q4[0].d, q4[0].f);
                end
                if (f4_ready) void'(q4.pop_front());
            end
        end
    end

    // Downstream ready: 1,0,0,1 pattern during the stream test, else always ready
    initial begin
        int unsigned idx;
        logic [3:0] pat;
        pat = 4'b1001;
        idx = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode) begin
                out_ready = pat[3 - idx];
                idx = (idx + 1) % 4;
            end else begin
                out_ready = 1'b1;
                idx = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    task automatic send(input bit sel4, input logic [31:0] d, input logic [1:0] m,
                        input logic [31:0] ed, input logic [2:0] ef);
        exp_t e;
        int unsigned n;
        bit done;
        e.d = ed;
        e.f = ef & FLAG_MASK;
        n = 0;
        done = 1'b0;
        if (sel4) begin
            f4_valid = 1'b1; f4_data = d; f4_round = m;
        end else begin
            in_valid = 1'b1; in_data = d; in_round = m;
        end
        while (!done) begin
            @(negedge clk);
            if (sel4 ? f4_in_ready : in_ready) begin
                done = 1'b1;
                if (sel4) q4.push_back(e);
                else q.push_back(e);
            end
            @(posedge clk);
            #1;
            if (!done) begin
                n++;
                if (n > 100) begin
                    total++;
                    bad++;
                    $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, required 1", n);
                    done = 1'b1;
                end
            end
        end
        if (sel4) f4_valid = 1'b0;
        else in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while ((q.size() != 0 || q4.size() != 0) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (q.size() != 0 || q4.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d/%0d results outstanding, required 0", q.size(), q4.size());
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        in_valid = 1'b0; in_data = '0; in_round = 2'b00;
        f4_valid = 1'b0; f4_data = '0; f4_round = 2'b00; f4_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_flags", {29'd0, out_flags}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_f4_valid", {31'd0, f4_out_valid}, 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors, FRACTION_BITS=0
        send(0, 32'h3FC00000, 2'b10, 32'h00000002, NX);
        send(0, 32'h3FC00000, 2'b00, 32'h00000001, NX);
        send(0, 32'h3FC00000, 2'b01, 32'h00000002, NX);
        send(0, 32'h40200000, 2'b10, 32'h00000002, NX);
        send(0, 32'h40200000, 2'b01, 32'h00000003, NX);
        send(0, 32'hC0200000, 2'b00, 32'hFFFFFFFE, NX);
        send(0, 32'hC0200000, 2'b11, 32'hFFFFFFFD, NX);
        send(0, 32'hCF000000, 2'b00, 32'h80000000, NF);
        send(0, 32'h4F32D05E, 2'b00, 32'h7FFFFFFF, OV);
        send(0, 32'hFF800000, 2'b00, 32'h80000000, OV);
        send(0, 32'h7F800000, 2'b01, 32'h7FFFFFFF, OV);
        send(0, 32'h7FC00000, 2'b00, 32'h00000000, NV);
        send(0, 32'h80000000, 2'b11, 32'h00000000, NF);
        send(0, 32'h00000001, 2'b00, 32'h00000000, NX);
        send(0, 32'h80400000, 2'b11, 32'h00000000, NX);
        send(0, 32'h3F000000, 2'b01, 32'h00000001, NX);
        send(0, 32'h3F000000, 2'b10, 32'h00000000, NX);
        send(0, 32'h3FE00000, 2'b10, 32'h00000002, NX);
        send(0, 32'h40600000, 2'b10, 32'h00000004, NX);
        send(0, 32'hC0400000, 2'b10, 32'hFFFFFFFD, NF);
        send(0, 32'h4EFFFFFF, 2'b00, 32'h7FFFFF80, NF);
        send(0, 32'h4F000000, 2'b00, 32'h7FFFFFFF, OV);
        send(0, 32'hCF000001, 2'b00, 32'h80000000, OV);
        send(0, 32'hBF400000, 2'b00, 32'h00000000, NX);
        send(0, 32'hBF400000, 2'b01, 32'hFFFFFFFF, NX);
        send(0, 32'hBF400000, 2'b11, 32'hFFFFFFFF, NX);
        send(0, 32'h3E800000, 2'b11, 32'h00000000, NX);
        send(0, 32'h00800000, 2'b11, 32'h00000000, NX);
        send(0, 32'h80800000, 2'b11, 32'hFFFFFFFF, NX);
        send(0, 32'h3F800000, 2'b00, 32'h00000001, NF);
        drain();

        // FRACTION_BITS=4 instance
        send(1, 32'h3FC00000, 2'b00, 32'h00000018, NF);
        send(1, 32'h3D800000, 2'b00, 32'h00000001, NF);
        send(1, 32'h3D000000, 2'b01, 32'h00000001, NX);
        send(1, 32'h3D000000, 2'b10, 32'h00000000, NX);
        send(1, 32'hBFC00000, 2'b00, 32'hFFFFFFE8, NF);
        send(1, 32'h4E000000, 2'b00, 32'h7FFFFFFF, OV);
        drain();

        // Back-to-back stream under output back-pressure
        rdy_mode = 1'b1;
        send(0, 32'h3F800000, 2'b00, 32'h00000001, NF);
        send(0, 32'h40000000, 2'b00, 32'h00000002, NF);
        send(0, 32'h40400000, 2'b00, 32'h00000003, NF);
        send(0, 32'hC0800000, 2'b00, 32'hFFFFFFFC, NF);
        send(0, 32'h41200000, 2'b00, 32'h0000000A, NF);
        send(0, 32'h42C80000, 2'b00, 32'h00000064, NF);
        send(0, 32'hBF800000, 2'b00, 32'hFFFFFFFF, NF);
        send(0, 32'h447A0000, 2'b00, 32'h000003E8, NF);
        drain();
        rdy_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset with two values in flight
        send(0, 32'h40400000, 2'b00, 32'h00000003, NF);
        send(0, 32'h40000000, 2'b00, 32'h00000002, NF);
        resetn = 1'b0;
        q.delete();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        check("reset_flush_valid", {31'd0, out_valid}, 32'd0);
        check("reset_flush_data", out_data, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("no_stale_out", {31'd0, out_valid}, 32'd0);
        end

        // Pipeline still usable after the flush
        send(0, 32'hC0200000, 2'b01, 32'hFFFFFFFD, NX);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
